mux_select_arbiter: RTL and testbench
=====================================

Name: mux_select_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4-input multiplexer.
- Takes four request lines and drives the mux select pair {s1,s0}, so exactly one of inputs a/b/c/d is routed to y at a time.
- Registered outputs. A bounded tenure counter stops one source from holding the mux indefinitely.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles while another request is pending; legal range 2..255.
- CNT_W, default 8: tenure counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clock  input  1  system clock, rising-edge active.
- n_reset  input  1  asynchronous, active-low reset.
- req  input  4  request per mux input; bit0=a, bit1=b, bit2=c, bit3=d.
- s1  output  1  mux select MSB.
- s0  output  1  mux select LSB.
- grant  output  4  one-hot grant, same bit order as req.
- valid  output  1  high when grant is non-zero and {s1,s0} is meaningful.

Behaviour:
- Single clock; reset is asynchronous and active-low (n_reset). All state and outputs are registered.
- Reset values (applied immediately on n_reset low, including mid-grant):
  - state=IDLE, s1=0, s0=0, grant=4'b0000, valid=0, hold_cnt=0.
  - last=2'd3, so channel 0 has top priority after reset.
- States: IDLE, GRANT.
- Round-robin pick: search req starting at index last+1 mod 4, wrapping 3->0; first set bit wins.
- IDLE:
  - req==0: stay; outputs unchanged (s1/s0 retain last value, valid=0).
  - Any req set: next edge -> GRANT. Outputs become grant=onehot(pick), {s1,s0}=pick, valid=1, last=pick, hold_cnt=0.
  - Latency from req sampled high to grant/select visible: 1 clock.
- GRANT (current index cur):
  - req[cur]=1 and hold_cnt<MAX_HOLD-1: stay; hold_cnt++.
  - req[cur]=0, other requests pending: switch directly to next round-robin pick on the next edge, with no idle bubble. valid stays 1; hold_cnt=0.
  - req[cur]=0, no other requests: -> IDLE. grant=0, valid=0, {s1,s0} hold value.
  - req[cur]=1 and hold_cnt==MAX_HOLD-1: preempt.
    - Other request pending: switch to next pick, hold_cnt=0.
    - Otherwise: keep cur, hold_cnt saturates at MAX_HOLD-1.
- Simultaneous requests: only round-robin order decides; the current holder never wins re-arbitration at preemption while others are pending.
- req changes between edges are ignored; only values sampled at the rising edge matter.
- Invariants:
  - grant is always one-hot or zero.
  - valid == |grant.
  - {s1,s0} == index of grant whenever valid=1.

Optional Feature:
- Macro MUX_SEL_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 in GRANT with req[cur]=1, preemption is suppressed and hold_cnt saturates at MAX_HOLD-1. lock has no effect in IDLE or once req[cur] drops.
- Undefined: no lock port; preemption behaves exactly as above.

Decomposition:
- Shared package mux_sel_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - typedef logic [1:0] sel_t.
  - constant NUM_CH=4.
  - function rr_pick(req, last) returning sel_t.
- One natural sub-module: rr_priority_pick, a combinational rotate-and-find-first returning pick index and any flag. Used by the arbiter FSM.

Test Plan (MAX_HOLD=4 unless stated):
- Reset with req=4'b1111 held, release n_reset: first edge -> grant=0001, {s1,s0}=00, valid=1.
- Single req=4'b0100 from IDLE: one edge later grant=0100, {s1,s0}=10. Drop req: next edge grant=0000, valid=0, {s1,s0} stays 10.
- req=4'b1111 held continuously: grant rotates 0001->0010->0100->1000->0001, each held exactly 4 cycles; {s1,s0} follows 00,01,10,11.
- req=4'b1000 alone for 20 cycles: grant stays 1000 throughout, no preemption, hold_cnt saturates at 3.
- Holder ch1 drops req while req=4'b1001: next edge grant=1000 (ch3 after ch1), valid never deasserts.
- Assert n_reset=0 mid-grant on ch2: outputs clear to 0 immediately without a clock edge. After release, req=4'b0100 is granted on the first edge.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the mux select arbiter.
package mux_sel_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [1:0] sel_t;

    // Round-robin search starting at last+1, wrapping; first set bit wins.
    // Returns 'last' when no request is set (caller qualifies with |req).
    function automatic sel_t rr_pick(logic [NUM_CH-1:0] req, sel_t last);
        sel_t idx;
        rr_pick = last;
        // Walk from the farthest offset down so the nearest set bit is written last.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + sel_t'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [NUM_CH-1:0] sel2onehot(sel_t s);
        sel2onehot    = '0;
        sel2onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-find-first over the four request lines.
module rr_priority_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  sel_t              last_i,
    output sel_t              pick_o,
    output logic              any_o
);

    // Pick the next channel after last_i and flag whether any request exists.
    always_comb begin
        pick_o = rr_pick(req_i, last_i);
        any_o  = |req_i;
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select pair with a bounded tenure.
// Optional feature: define MUX_SEL_LOCK_EN to add a 'lock' input that suppresses
// preemption of the current holder while its request stays high.
module mux_select_arbiter
    import mux_sel_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [NUM_CH-1:0] req,
`ifdef MUX_SEL_LOCK_EN
    input  logic              lock,
`endif
    output logic              s1,
    output logic              s0,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    // Catch illegal configurations at elaboration time.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 2..255");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for MAX_HOLD");
    end

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

    arb_state_t        state_q;
    sel_t              last_q;
    sel_t              sel_q;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [NUM_CH-1:0] grant_q;
    logic              valid_q;

    logic [NUM_CH-1:0] req_masked;
    sel_t              pick;
    logic              pick_any;
    logic              lock_hold;

`ifdef MUX_SEL_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // In GRANT the holder is masked out so pick_any means "someone else is waiting".
    always_comb begin
        req_masked = req;
        if (state_q == GRANT) begin
            req_masked = req & ~sel2onehot(last_q);
        end
    end

    rr_priority_pick u_pick (
        .req_i  (req_masked),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (pick_any)
    );

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            last_q     <= sel_t'(2'd3);
            sel_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q    <= GRANT;
                        grant_q    <= sel2onehot(pick);
                        sel_q      <= pick;
                        valid_q    <= 1'b1;
                        last_q     <= pick;
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (req[last_q]) begin
                        if (hold_cnt_q < HoldMax) begin
                            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                        end else if (pick_any && !lock_hold) begin
                            // Tenure expired with others waiting: hand over.
                            grant_q    <= sel2onehot(pick);
                            sel_q      <= pick;
                            last_q     <= pick;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= HoldMax;
                        end
                    end else if (pick_any) begin
                        // Holder released: switch with no idle bubble.
                        grant_q    <= sel2onehot(pick);
                        sel_q      <= pick;
                        last_q     <= pick;
                        hold_cnt_q <= '0;
                    end else begin
                        // Nobody left; select lines keep their last value.
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        valid_q    <= 1'b0;
                        hold_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed self-checking bench for mux_select_arbiter with MAX_HOLD=4.
module tb_mux_select_arbiter;

    logic       clock;
    logic       n_reset;
    logic [3:0] req;
`ifdef MUX_SEL_LOCK_EN
    logic       lock;
`endif
    logic       s1;
    logic       s0;
    logic [3:0] grant;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    mux_select_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .req     (req),
`ifdef MUX_SEL_LOCK_EN
        .lock    (lock),
`endif
        .s1      (s1),
        .s0      (s0),
        .grant   (grant),
        .valid   (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        req     = 4'b0000;
        step();
        step();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        req     = 4'b1111;
        #2;
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL reset_async: got grant=%b sel=%b%b valid=%b, want 0000/00/0",
                     grant, s1, s0, valid);
        end
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL reset_held: got grant=%b sel=%b%b valid=%b, want 0000/00/0",
                     grant, s1, s0, valid);
        end
        n_reset = 1'b1;
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0001_00_1) begin
            n_fail++;
            $display("FAIL reset_first_grant: got grant=%b sel=%b%b valid=%b, want 0001/00/1",
                     grant, s1, s0, valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0100_10_1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b sel=%b%b valid=%b, want 0100/10/1",
                     grant, s1, s0, valid);
        end
        req = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if ({grant, s1, s0, valid} !== 7'b0000_10_0) begin
                n_fail++;
                $display("FAIL single_release[%0d]: got grant=%b sel=%b%b valid=%b, want 0000/10/0",
                         k, grant, s1, s0, valid);
            end
        end
    endtask

    task automatic test_rotate();
        int         idx;
        logic [3:0] eg;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            step();
            idx = (k / 4) % 4;
            eg  = 4'b0001 << idx;
            n_tests++;
            if ({grant, s1, s0, valid} !== {eg, idx[1:0], 1'b1}) begin
                n_fail++;
                $display("FAIL rotate[%0d]: got grant=%b sel=%b%b valid=%b, want %b/%b/1",
                         k, grant, s1, s0, valid, eg, idx[1:0]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            step();
            n_tests++;
            if ({grant, s1, s0, valid} !== 7'b1000_11_1) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got grant=%b sel=%b%b valid=%b, want 1000/11/1",
                         k, grant, s1, s0, valid);
            end
            if (k >= 3) begin
                n_tests++;
                if (dut.hold_cnt_q !== 8'd3) begin
                    n_fail++;
                    $display("FAIL saturate_cnt[%0d]: got hold_cnt=%0d, want 3",
                             k, dut.hold_cnt_q);
                end
            end
        end
    endtask

    task automatic test_drop_switch();
        do_reset();
        req = 4'b0010;
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0010_01_1) begin
            n_fail++;
            $display("FAIL drop_first: got grant=%b sel=%b%b valid=%b, want 0010/01/1",
                     grant, s1, s0, valid);
        end
        req = 4'b1001;
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b1000_11_1) begin
            n_fail++;
            $display("FAIL drop_switch: got grant=%b sel=%b%b valid=%b, want 1000/11/1",
                     grant, s1, s0, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ei;
        logic [3:0] eg;
        do_reset();
        req = 4'b1010;
        for (int k = 0; k < 12; k++) begin
            step();
            ei = ((k / 4) % 2 == 0) ? 2'd1 : 2'd3;
            eg = 4'b0001 << ei;
            n_tests++;
            if ({grant, s1, s0, valid} !== {eg, ei, 1'b1}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got grant=%b sel=%b%b valid=%b, want %b/%b/1",
                         k, grant, s1, s0, valid, eg, ei);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0100;
        step();
        step();
        #2;
        n_reset = 1'b0;
        #1;
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0000_00_0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got grant=%b sel=%b%b valid=%b, want 0000/00/0",
                     grant, s1, s0, valid);
        end
        #2;
        n_reset = 1'b1;
        req     = 4'b0100;
        step();
        n_tests++;
        if ({grant, s1, s0, valid} !== 7'b0100_10_1) begin
            n_fail++;
            $display("FAIL mid_reset_regrant: got grant=%b sel=%b%b valid=%b, want 0100/10/1",
                     grant, s1, s0, valid);
        end
    endtask

    initial begin
        n_reset = 1'b0;
        req     = 4'b0000;
`ifdef MUX_SEL_LOCK_EN
        lock    = 1'b0;
`endif
        #1;
        test_reset();
        test_single();
        test_rotate();
        test_saturate();
        test_drop_switch();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
